mul_div_unit: RTL

//  Iterative multiply/divide unit in the execute stage, beside the ALU. Takes the same SrcA/SrcB operands.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_iter_step.sv | 41 ++++
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds op codes, FSM states, the iteration bound and the conditional-negate helper.
package mdu_pkg;

  localparam int unsigned MDU_DATA_WIDTH = 32;
  localparam int unsigned MDU_OP_WIDTH   = 3;
  localparam int unsigned ITER_LAST      = MDU_DATA_WIDTH - 1;

  localparam logic [MDU_OP_WIDTH-1:0] MD_MULT  = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] MD_MULTU = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] MD_DIV   = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] MD_DIVU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] MD_MTHI  = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } mdu_state_e;

  // Two's-complement negate when neg is set; also used to take magnitudes.
  function automatic logic [MDU_DATA_WIDTH-1:0] mdu_cneg(
    input logic [MDU_DATA_WIDTH-1:0] v,
    input logic                      neg
  );
    return neg ? (~v + MDU_DATA_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the multiply/divide datapath on {acc, q}.
// Multiply: shift-add of one multiplier bit. Divide: one restoring shift-subtract step.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  i_is_div,
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic [DATA_WIDTH-1:0] i_opnd,
  output logic [DATA_WIDTH-1:0] o_acc_c,
  output logic [DATA_WIDTH-1:0] o_q_c
);

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_shl;
  logic [DATA_WIDTH-1:0] w_diff;

  always_comb begin
    o_acc_c = '0;
    o_q_c   = '0;
    w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opnd} : '0);
    // Shifted partial remainder needs one extra bit before the trial subtract.
    w_shl   = {i_acc, i_q[DATA_WIDTH-1]};
    w_diff  = w_shl[DATA_WIDTH-1:0] - i_opnd;
    if (i_is_div) begin
      if (w_shl >= {1'b0, i_opnd}) begin
        o_acc_c = w_diff;
        o_q_c   = {i_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        o_acc_c = w_shl[DATA_WIDTH-1:0];
        o_q_c   = {i_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc_c = w_sum[DATA_WIDTH:1];
      o_q_c   = {w_sum[0], i_q[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One result bit per cycle on magnitudes; signs are applied in a final FIX cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = MDU_OP_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [OP_WIDTH-1:0]   MDOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_acc;
  logic [DW-1:0]    r_q;
  logic [DW-1:0]    r_opnd;
  logic [DW-1:0]    r_hi;
  logic [DW-1:0]    r_lo;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz_out;

  logic          w_is_md;
  logic          w_is_div_op;
  logic          w_is_signed;
  logic          w_sa;
  logic          w_sb;
  logic [DW-1:0] w_mag_a;
  logic [DW-1:0] w_mag_b;
  logic [DW-1:0] w_acc_next;
  logic [DW-1:0] w_q_next;
  logic [PW-1:0] w_prod;
  logic [DW-1:0] w_quot;
  logic [DW-1:0] w_rem;

  mdu_iter_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter_step (
    .i_is_div(r_is_div),
    .i_acc   (r_acc),
    .i_q     (r_q),
    .i_opnd  (r_opnd),
    .o_acc_c (w_acc_next),
    .o_q_c   (w_q_next)
  );

  // Op decode and operand magnitudes at latch time.
  always_comb begin
    w_is_md     = (MDOp == MD_MULT) || (MDOp == MD_MULTU) ||
                  (MDOp == MD_DIV)  || (MDOp == MD_DIVU);
    w_is_div_op = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
    w_is_signed = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    w_sa        = w_is_signed & SrcA[DW-1];
    w_sb        = w_is_signed & SrcB[DW-1];
    w_mag_a     = mdu_cneg(SrcA, w_sa);
    w_mag_b     = mdu_cneg(SrcB, w_sb);
  end

  // Sign fix-up of the finished magnitude results.
  always_comb begin
    w_prod = {r_acc, r_q};
    if (r_neg_res) begin
      w_prod = ~w_prod + PW'(1);
    end
    w_quot = mdu_cneg(r_q, r_neg_res);
    w_rem  = mdu_cneg(r_acc, r_neg_rem);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start && w_is_md) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_is_div  <= w_is_div_op;
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_dbz     <= 1'b0;
            r_acc     <= '0;
            if (w_is_div_op) begin
              r_q    <= w_mag_a;
              r_opnd <= w_mag_b;
              // Zero divisor skips the iterations; HI later takes the raw dividend.
              if (SrcB == '0) begin
                r_dbz   <= 1'b1;
                r_acc   <= SrcA;
                r_state <= S_FIX;
              end else begin
                r_state <= S_DIV;
              end
            end else begin
              r_q     <= w_mag_b;
              r_opnd  <= w_mag_a;
              r_state <= S_MUL;
            end
          end else if (Start && (MDOp == MD_MTHI)) begin
            r_hi <= SrcA;
          end else if (Start && (MDOp == MD_MTLO)) begin
            r_lo <= SrcA;
          end
        end
        S_MUL, S_DIV: begin
          r_acc <= w_acc_next;
          r_q   <= w_q_next;
          if (r_cnt == CNT_W'(ITER_LAST)) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (r_dbz) begin
            r_hi <= r_acc;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[PW-1:DW];
            r_lo <= w_prod[DW-1:0];
          end
          r_done    <= 1'b1;
          r_dbz_out <= r_dbz;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz_out;
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule
